// File: rtl/eth_rx_frame_ctrl_if.sv
// Receive-side nibble stream in, payload byte stream and header/statistics out.
interface eth_rx_frame_ctrl_if;
    logic        rx_en;
    logic        rx_nib_vld;
    logic [3:0]  rx_nib;
    logic [7:0]  out_data;
    logic        out_last;
    logic        out_valid;
    logic        out_ready;
    logic [47:0] hdr_dst;
    logic [47:0] hdr_src;
    logic [15:0] hdr_type;
    logic        hdr_valid;
    logic        frame_abort;
    logic [15:0] stat_frames;
    logic [15:0] stat_drops;

    modport master (
        output rx_en, rx_nib_vld, rx_nib, out_ready,
        input  out_data, out_last, out_valid, hdr_dst, hdr_src, hdr_type,
               hdr_valid, frame_abort, stat_frames, stat_drops
    );
    modport slave (
        input  rx_en, rx_nib_vld, rx_nib, out_ready,
        output out_data, out_last, out_valid, hdr_dst, hdr_src, hdr_type,
               hdr_valid, frame_abort, stat_frames, stat_drops
    );
endinterface

// File: rtl/eth_rx_frame_ctrl.sv
// Ethernet RX framer: preamble/SFD hunt, header capture, DA filter, 4-deep payload FIFO.
// Pushed byte appears the cycle after push; head holds under stall, a push into a full FIFO aborts the frame.
module eth_rx_fifo #(
    parameter int W     = 9,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    output logic         full,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         vld
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0]   cnt;
    logic          do_push, do_pop;

    assign vld     = (cnt != '0);
    assign full    = (cnt == (AW+1)'(DEPTH));
    assign head    = mem[rp];
    assign do_pop  = pop & vld;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wp] <= push_dat;
                wp      <= wp + 1'b1;
            end
            if (do_pop) rp <= rp + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

module eth_rx_frame_ctrl #(
    parameter logic [47:0] MAC_ADDR    = 48'h54_ff_01_21_23_24,
    parameter bit          PROMISC     = 1'b0,
    parameter int          MIN_PRE     = 7,
    parameter int          MAX_PAYLOAD = 1500
) (
    input logic clk,
    input logic rst,
    eth_rx_frame_ctrl_if.slave bus
);
    localparam int PW = $clog2(MAX_PAYLOAD + 2);
    localparam logic [3:0]    MIN_PRE_L = 4'(MIN_PRE);
    localparam logic [PW-1:0] MAX_PAY_L = PW'(MAX_PAYLOAD);

    typedef enum logic [2:0] {IDLE, PREAMBLE, HEADER, PAYLOAD, DROP} state_t;
    state_t state, state_n;

    logic [3:0]    pre_cnt, lo_nib, byte_idx;
    logic          nib_hi, held_vld;
    logic [7:0]    held;
    logic [PW-1:0] pay_cnt;
    logic [47:0]   sh_dst, sh_src, dst_full;
    logic [15:0]   sh_type;
    logic [7:0]    cur_byte;
    logic          nib_ok, byte_done, addr_ok;
    logic          push, push_last, ovf, fifo_full, fifo_vld;
    logic [8:0]    fifo_head;
    logic          hdr_done, do_abort, do_drop, do_frame;
    logic          hdr_valid_r, abort_r;
    logic [15:0]   frames_r, drops_r;
    logic [47:0]   hdr_dst_r, hdr_src_r;
    logic [15:0]   hdr_type_r;

    assign nib_ok    = bus.rx_en & bus.rx_nib_vld;
    assign byte_done = nib_ok & nib_hi;
    assign cur_byte  = {bus.rx_nib, lo_nib};
    assign dst_full  = {sh_dst[39:0], cur_byte};
    assign addr_ok   = PROMISC || (dst_full == MAC_ADDR) || (dst_full == 48'hFFFF_FFFF_FFFF);
    // A same-cycle pop frees the slot, so only a stalled full FIFO overflows.
    assign ovf       = push & fifo_full & ~(fifo_vld & bus.out_ready);

    always_comb begin
        state_n   = state;
        push      = 1'b0;
        push_last = 1'b0;
        hdr_done  = 1'b0;
        do_abort  = 1'b0;
        do_drop   = 1'b0;
        do_frame  = 1'b0;
        case (state)
            IDLE: if (nib_ok && bus.rx_nib == 4'h5) state_n = PREAMBLE;
            PREAMBLE: begin
                if (!bus.rx_en) state_n = IDLE;
                else if (nib_ok && bus.rx_nib != 4'h5) begin
                    if (bus.rx_nib == 4'hD && pre_cnt >= MIN_PRE_L) state_n = HEADER;
                    else state_n = DROP;
                end
            end
            HEADER: begin
                if (!bus.rx_en) begin
                    state_n = IDLE;
                    do_drop = 1'b1;
                end else if (byte_done && byte_idx == 4'd5 && !addr_ok) begin
                    state_n = DROP;
                    do_drop = 1'b1;
                end else if (byte_done && byte_idx == 4'd13) begin
                    state_n  = PAYLOAD;
                    hdr_done = 1'b1;
                end
            end
            PAYLOAD: begin
                if (!bus.rx_en) begin
                    state_n = IDLE;
                    if (held_vld && !nib_hi) begin
                        push      = 1'b1;
                        push_last = 1'b1;
                        do_abort  = ovf;
                        do_frame  = ~ovf;
                    end else begin
                        do_abort = 1'b1;
                    end
                end else if (byte_done) begin
                    if (pay_cnt >= MAX_PAY_L) begin
                        do_abort = 1'b1;
                        state_n  = DROP;
                    end else if (held_vld) begin
                        push = 1'b1;
                        if (ovf) begin
                            do_abort = 1'b1;
                            state_n  = DROP;
                        end
                    end
                end
            end
            DROP:    if (!bus.rx_en) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pre_cnt     <= '0;
            lo_nib      <= '0;
            byte_idx    <= '0;
            nib_hi      <= 1'b0;
            held        <= '0;
            held_vld    <= 1'b0;
            pay_cnt     <= '0;
            sh_dst      <= '0;
            sh_src      <= '0;
            sh_type     <= '0;
            hdr_dst_r   <= '0;
            hdr_src_r   <= '0;
            hdr_type_r  <= '0;
            hdr_valid_r <= 1'b0;
            abort_r     <= 1'b0;
            frames_r    <= '0;
            drops_r     <= '0;
        end else begin
            state       <= state_n;
            hdr_valid_r <= hdr_done;
            abort_r     <= do_abort;
            if (do_frame && frames_r != 16'hFFFF) frames_r <= frames_r + 1'b1;
            if ((do_drop || do_abort) && drops_r != 16'hFFFF) drops_r <= drops_r + 1'b1;

            if (state == IDLE) pre_cnt <= 4'd1;
            else if (state == PREAMBLE && nib_ok && bus.rx_nib == 4'h5 && pre_cnt != 4'hF)
                pre_cnt <= pre_cnt + 1'b1;

            if (state != HEADER && state != PAYLOAD) nib_hi <= 1'b0;
            else if (nib_ok) nib_hi <= ~nib_hi;
            if (nib_ok && !nib_hi) lo_nib <= bus.rx_nib;

            if (state != HEADER) byte_idx <= '0;
            else if (byte_done) begin
                byte_idx <= byte_idx + 1'b1;
                if (byte_idx < 4'd6)       sh_dst  <= dst_full;
                else if (byte_idx < 4'd12) sh_src  <= {sh_src[39:0], cur_byte};
                else                       sh_type <= {sh_type[7:0], cur_byte};
            end
            if (hdr_done) begin
                hdr_dst_r  <= sh_dst;
                hdr_src_r  <= sh_src;
                hdr_type_r <= {sh_type[7:0], cur_byte};
            end

            if (state != PAYLOAD) begin
                held_vld <= 1'b0;
                pay_cnt  <= '0;
            end else if (byte_done && !do_abort) begin
                held     <= cur_byte;
                held_vld <= 1'b1;
                pay_cnt  <= pay_cnt + 1'b1;
            end
        end
    end

    eth_rx_fifo #(.W(9), .DEPTH(4)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push & ~ovf),
        .push_dat ({push_last, held}),
        .full     (fifo_full),
        .pop      (bus.out_ready),
        .head     (fifo_head),
        .vld      (fifo_vld)
    );

    assign bus.out_data    = fifo_head[7:0];
    assign bus.out_last    = fifo_head[8];
    assign bus.out_valid   = fifo_vld;
    assign bus.hdr_dst     = hdr_dst_r;
    assign bus.hdr_src     = hdr_src_r;
    assign bus.hdr_type    = hdr_type_r;
    assign bus.hdr_valid   = hdr_valid_r;
    assign bus.frame_abort = abort_r;
    assign bus.stat_frames = frames_r;
    assign bus.stat_drops  = drops_r;
endmodule

// File: tb/tb_eth_rx_frame_ctrl.sv
// Directed frames against eth_rx_frame_ctrl; a negedge monitor pops expected bytes/headers from queues.
module tb_eth_rx_frame_ctrl;
    localparam logic [47:0] MAC   = 48'h54_ff_01_21_23_24;
    localparam logic [47:0] OTHER = 48'h11_22_33_44_55_66;
    localparam logic [47:0] SRC   = 48'h12_34_56_78_9a_bc;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    eth_rx_frame_ctrl_if bus();
    eth_rx_frame_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    logic [8:0]   exp_q [$];
    logic [111:0] hdr_q [$];
    logic [8:0]   be;
    logic [111:0] he;
    int n_vec = 0, n_bad = 0, hdr_cnt = 0, abort_cnt = 0;
    int h0, a0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.frame_abort) abort_cnt++;
            if (bus.hdr_valid) begin
                hdr_cnt++;
                n_vec++;
                if (hdr_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL hdr_unexpected: got dst %0h expected no header", bus.hdr_dst);
                end else begin
                    he = hdr_q.pop_front();
                    if ({bus.hdr_dst, bus.hdr_src, bus.hdr_type} !== he) begin
                        n_bad++;
                        $display("FAIL hdr_fields: got %0h expected %0h",
                                 {bus.hdr_dst, bus.hdr_src, bus.hdr_type}, he);
                    end
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL out_unexpected: got last/data %0h expected none",
                             {bus.out_last, bus.out_data});
                end else begin
                    be = exp_q.pop_front();
                    if ({bus.out_last, bus.out_data} !== be) begin
                        n_bad++;
                        $display("FAIL out_byte: got last/data %0h expected %0h",
                                 {bus.out_last, bus.out_data}, be);
                    end
                end
            end
        end
    end

    task automatic send_nib(input logic [3:0] n);
        bus.rx_en      = 1'b1;
        bus.rx_nib_vld = 1'b1;
        bus.rx_nib     = n;
        @(posedge clk); #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_nib(b[3:0]);
        send_nib(b[7:4]);
    endtask

    task automatic send_frame(input logic [47:0] dst, input int nhdr, input int npay,
                              input bit odd, input int npre, input bit fin);
        logic [111:0] h;
        h = {dst, SRC, 16'h0800};
        for (int i = 0; i < npre; i++) send_nib(4'h5);
        send_nib(4'hD);
        for (int i = 0; i < nhdr; i++) send_byte(h[111-8*i -: 8]);
        if (nhdr == 14)
            for (int i = 1; i <= npay; i++) send_byte(8'(i));
        if (odd) send_nib(4'h0);
        bus.rx_nib_vld = 1'b0;
        if (fin) begin
            bus.rx_en = 1'b0;
            for (int i = 0; i < 4; i++) begin @(posedge clk); #1; end
        end
    endtask

    task automatic expect_bytes(input int n, input bit last_on_end);
        for (int i = 1; i <= n; i++) exp_q.push_back({last_on_end && (i == n), 8'(i)});
    endtask

    task automatic drain();
        for (int k = 0; k < 400 && (exp_q.size() != 0 || hdr_q.size() != 0); k++) @(posedge clk);
        @(negedge clk);
        chk("drain_out", 64'(exp_q.size()), 0);
        chk("drain_hdr", 64'(hdr_q.size()), 0);
        exp_q.delete();
        hdr_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.rx_en = 1'b0; bus.rx_nib_vld = 1'b0; bus.rx_nib = 4'h0; bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 64'(bus.out_valid), 0);
        chk("rst_frames", 64'(bus.stat_frames), 0);
        chk("rst_drops", 64'(bus.stat_drops), 0);
        chk("rst_hdr_dst", 64'(bus.hdr_dst), 0);
        @(posedge clk); #1;

        // 1: good frame, 46 payload bytes
        h0 = hdr_cnt; a0 = abort_cnt;
        hdr_q.push_back({MAC, SRC, 16'h0800});
        expect_bytes(46, 1'b1);
        send_frame(MAC, 14, 46, 1'b0, 15, 1'b1);
        drain();
        chk("t1_hdr_pulses", 64'(hdr_cnt - h0), 1);
        chk("t1_aborts", 64'(abort_cnt - a0), 0);
        chk("t1_frames", 64'(bus.stat_frames), 1);
        chk("t1_drops", 64'(bus.stat_drops), 0);
        chk("t1_hdr_type", 64'(bus.hdr_type), 16'h0800);

        // 2: destination filtered
        h0 = hdr_cnt;
        send_frame(OTHER, 14, 46, 1'b0, 15, 1'b1);
        drain();
        chk("t2_hdr_pulses", 64'(hdr_cnt - h0), 0);
        chk("t2_drops", 64'(bus.stat_drops), 1);
        chk("t2_frames", 64'(bus.stat_frames), 1);

        // 3: consumer stalled -> overflow abort, queued bytes drain later
        h0 = hdr_cnt; a0 = abort_cnt;
        bus.out_ready = 1'b0;
        hdr_q.push_back({MAC, SRC, 16'h0800});
        send_frame(MAC, 14, 46, 1'b0, 15, 1'b1);
        @(negedge clk);
        chk("t3_aborts", 64'(abort_cnt - a0), 1);
        chk("t3_drops", 64'(bus.stat_drops), 2);
        chk("t3_valid_stalled", 64'(bus.out_valid), 1);
        chk("t3_head_stable", 64'({bus.out_last, bus.out_data}), 9'h001);
        expect_bytes(4, 1'b0);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        drain();
        chk("t3_hdr_pulses", 64'(hdr_cnt - h0), 1);
        chk("t3_frames", 64'(bus.stat_frames), 1);

        // 4: runt after 6 header bytes
        h0 = hdr_cnt;
        send_frame(MAC, 6, 0, 1'b0, 15, 1'b1);
        drain();
        chk("t4_drops", 64'(bus.stat_drops), 3);
        chk("t4_hdr_pulses", 64'(hdr_cnt - h0), 0);

        // 5: short preamble ignored, then odd nibble count aborts
        h0 = hdr_cnt;
        send_frame(MAC, 14, 46, 1'b0, 3, 1'b1);
        drain();
        chk("t5_short_pre_hdr", 64'(hdr_cnt - h0), 0);
        chk("t5_short_pre_drops", 64'(bus.stat_drops), 3);
        a0 = abort_cnt;
        hdr_q.push_back({MAC, SRC, 16'h0800});
        expect_bytes(45, 1'b0);
        send_frame(MAC, 14, 46, 1'b1, 15, 1'b1);
        drain();
        chk("t5_odd_aborts", 64'(abort_cnt - a0), 1);
        chk("t5_drops", 64'(bus.stat_drops), 4);
        chk("t5_frames", 64'(bus.stat_frames), 1);

        // 6: reset mid-payload, then a clean frame
        bus.out_ready = 1'b0;
        hdr_q.push_back({MAC, SRC, 16'h0800});
        send_frame(MAC, 14, 3, 1'b0, 15, 1'b0);
        @(negedge clk);
        chk("t6_pre_rst_valid", 64'(bus.out_valid), 1);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("t6_rst_valid", 64'(bus.out_valid), 0);
        chk("t6_rst_frames", 64'(bus.stat_frames), 0);
        chk("t6_rst_drops", 64'(bus.stat_drops), 0);
        chk("t6_rst_hdr_dst", 64'(bus.hdr_dst), 0);
        exp_q.delete();
        hdr_q.delete();
        #1;
        rst = 1'b0;
        bus.rx_en = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin @(posedge clk); #1; end
        hdr_q.push_back({MAC, SRC, 16'h0800});
        expect_bytes(46, 1'b1);
        send_frame(MAC, 14, 46, 1'b0, 15, 1'b1);
        drain();
        chk("t6_frames", 64'(bus.stat_frames), 1);
        chk("t6_drops", 64'(bus.stat_drops), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
